// File: rtl/gamepad_pmod_rx_if.sv
// rtl/gamepad_pmod_rx_if.sv - PMOD pin bundle and decoded pad state
// master = receiver (consumes pins, drives pad state); slave = pin source / paddle logic.
interface gamepad_pmod_rx_if #(
   parameter int BITS_PER_PAD = 12
);
   logic                    pmod_clk;
   logic                    pmod_latch;
   logic                    pmod_data;
   logic [BITS_PER_PAD-1:0] p1_buttons;
   logic [BITS_PER_PAD-1:0] p2_buttons;
   logic                    p1_present;
   logic                    p2_present;
   logic                    frame_valid;
   logic                    frame_err;
   logic [7:0]              err_count;
   logic                    link_up;

   modport master (
      input  pmod_clk, pmod_latch, pmod_data,
      output p1_buttons, p2_buttons, p1_present, p2_present,
      output frame_valid, frame_err, err_count, link_up
   );

   modport slave (
      output pmod_clk, pmod_latch, pmod_data,
      input  p1_buttons, p2_buttons, p1_present, p2_present,
      input  frame_valid, frame_err, err_count, link_up
   );
endinterface

// File: rtl/gamepad_pmod_rx.sv
// rtl/gamepad_pmod_rx.sv - TT Gamepad PMOD serial receiver
// Synchronizes the three PMOD pins, shifts a frame and validates its length on the latch edge.
module gamepad_pmod_rx #(
   parameter int BITS_PER_PAD   = 12,
   parameter int NUM_PADS       = 2,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic               clk,
   input  logic               rst,
   gamepad_pmod_rx_if.master  bus
);
   localparam int FRAME_BITS = BITS_PER_PAD * NUM_PADS;
   localparam int CNT_W      = $clog2(FRAME_BITS + 2);
   localparam int TO_W       = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_BITS + 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   // [0]/[1] synchronizer stages, [2] edge history
   logic [2:0]              clk_s, latch_s;
   logic [1:0]              data_s;
   logic                    rise_clk, rise_latch, good;
   logic [FRAME_BITS-1:0]   sr, sr_nxt;
   logic [CNT_W-1:0]        bit_cnt, cnt_nxt;
   logic [TO_W-1:0]         to_cnt, to_nxt;
   logic [BITS_PER_PAD-1:0] raw1, raw2;
   logic [BITS_PER_PAD-1:0] p1_q, p2_q, p1_n, p2_n;
   logic                    p1p_q, p2p_q, p1p_n, p2p_n;
   logic                    valid_q, valid_n, err_q, err_n, link_q, link_n;
   logic [7:0]              errc_q, errc_n;

   assign rise_clk   = clk_s[1] & ~clk_s[2];
   assign rise_latch = latch_s[1] & ~latch_s[2];
   assign good       = rise_latch && (bit_cnt == CNT_FULL);
   assign raw1       = sr[FRAME_BITS-1 -: BITS_PER_PAD];
   assign raw2       = sr[FRAME_BITS-BITS_PER_PAD-1 -: BITS_PER_PAD];

   always_comb begin
      sr_nxt  = sr;
      cnt_nxt = bit_cnt;
      to_nxt  = to_cnt;
      p1_n    = p1_q;
      p2_n    = p2_q;
      p1p_n   = p1p_q;
      p2p_n   = p2p_q;
      valid_n = 1'b0;
      err_n   = 1'b0;
      errc_n  = errc_q;
      link_n  = link_q;

      // A latch edge wins over a coincident clock edge, which is dropped.
      if (rise_latch) begin
         sr_nxt  = '0;
         cnt_nxt = '0;
         if (good) begin
            p1p_n   = ~&raw1;
            p2p_n   = ~&raw2;
            p1_n    = p1p_n ? raw1 : '0;
            p2_n    = p2p_n ? raw2 : '0;
            valid_n = 1'b1;
            link_n  = 1'b1;
         end else begin
            err_n = 1'b1;
            if (errc_q != 8'hFF)
               errc_n = errc_q + 8'd1;
         end
      end else if (rise_clk) begin
         sr_nxt = {sr[FRAME_BITS-2:0], data_s[1]};
         if (bit_cnt != CNT_OVF)
            cnt_nxt = bit_cnt + CNT_W'(1);
      end

      if (good)
         to_nxt = '0;
      else if (to_cnt != TO_LAST)
         to_nxt = to_cnt + TO_W'(1);

      if (!good && (to_nxt == TO_LAST)) begin
         link_n = 1'b0;
         p1_n   = '0;
         p2_n   = '0;
         p1p_n  = 1'b0;
         p2p_n  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s   <= '0;
         latch_s <= '0;
         data_s  <= '0;
         sr      <= '0;
         bit_cnt <= '0;
         to_cnt  <= '0;
         p1_q    <= '0;
         p2_q    <= '0;
         p1p_q   <= 1'b0;
         p2p_q   <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         errc_q  <= '0;
         link_q  <= 1'b0;
      end else begin
         clk_s   <= {clk_s[1:0], bus.pmod_clk};
         latch_s <= {latch_s[1:0], bus.pmod_latch};
         data_s  <= {data_s[0], bus.pmod_data};
         sr      <= sr_nxt;
         bit_cnt <= cnt_nxt;
         to_cnt  <= to_nxt;
         p1_q    <= p1_n;
         p2_q    <= p2_n;
         p1p_q   <= p1p_n;
         p2p_q   <= p2p_n;
         valid_q <= valid_n;
         err_q   <= err_n;
         errc_q  <= errc_n;
         link_q  <= link_n;
      end
   end

   assign bus.p1_buttons  = p1_q;
   assign bus.p2_buttons  = p2_q;
   assign bus.p1_present  = p1p_q;
   assign bus.p2_present  = p2p_q;
   assign bus.frame_valid = valid_q;
   assign bus.frame_err   = err_q;
   assign bus.err_count   = errc_q;
   assign bus.link_up     = link_q;
endmodule

// File: tb/tb_gamepad_pmod_rx.sv
// tb/tb_gamepad_pmod_rx.sv - self-checking bench for gamepad_pmod_rx
// Reference model keeps the sent bits in a queue and judges each frame when the latch is raised.
module tb_gamepad_pmod_rx;
   localparam int T = 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   gamepad_pmod_rx_if #(.BITS_PER_PAD(12)) bus ();

   gamepad_pmod_rx #(
      .BITS_PER_PAD(12),
      .NUM_PADS(2),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   bit          q[$];
   logic [11:0] m_p1, m_p2;
   logic        m_p1p, m_p2p, m_link;
   int          m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      q.delete();
      m_p1 = '0; m_p2 = '0; m_p1p = 1'b0; m_p2p = 1'b0; m_link = 1'b0; m_err = 0;
   endtask

   task automatic model_latch(output bit good);
      logic [11:0] raw1, raw2;
      good = (q.size() == 24);
      if (good) begin
         raw1 = '0; raw2 = '0;
         for (int i = 0; i < 12; i++) raw1 = {raw1[10:0], q[i]};
         for (int i = 12; i < 24; i++) raw2 = {raw2[10:0], q[i]};
         m_p1p = (raw1 != 12'hFFF);
         m_p2p = (raw2 != 12'hFFF);
         m_p1  = m_p1p ? raw1 : 12'h000;
         m_p2  = m_p2p ? raw2 : 12'h000;
         m_link = 1'b1;
      end else begin
         m_err = (m_err < 255) ? m_err + 1 : 255;
      end
      q.delete();
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".p1_buttons"}, 32'(bus.p1_buttons), 32'(m_p1));
      check({tag, ".p2_buttons"}, 32'(bus.p2_buttons), 32'(m_p2));
      check({tag, ".p1_present"}, 32'(bus.p1_present), 32'(m_p1p));
      check({tag, ".p2_present"}, 32'(bus.p2_present), 32'(m_p2p));
      check({tag, ".err_count"},  32'(bus.err_count),  32'(m_err));
      check({tag, ".link_up"},    32'(bus.link_up),    32'(m_link));
   endtask

   task automatic send_bit(input bit b);
      bus.pmod_data = b;
      cyc(2);
      bus.pmod_clk = 1'b1;
      q.push_back(b);
      cyc(3);
      bus.pmod_clk = 1'b0;
      cyc(2);
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic do_latch(input string tag, input bit with_clk);
      bit good;
      int nv = 0, ne = 0, both = 0;
      if (with_clk) bus.pmod_clk = 1'b1;
      bus.pmod_latch = 1'b1;
      model_latch(good);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         nv   += int'(bus.frame_valid);
         ne   += int'(bus.frame_err);
         both += int'(bus.frame_valid & bus.frame_err);
      end
      bus.pmod_latch = 1'b0;
      bus.pmod_clk   = 1'b0;
      cyc(2);
      check({tag, ".valid_pulses"}, nv, 32'(good));
      check({tag, ".err_pulses"},   ne, 32'(!good));
      check({tag, ".overlap"},      both, 0);
      check_outputs(tag);
   endtask

   task automatic good_frame(input string tag, input logic [11:0] a, input logic [11:0] b);
      send_bits({8'h00, a, b}, 24);
      do_latch(tag, 1'b0);
   endtask

   initial begin
      bit          prev_err;
      logic [11:0] a, b;
      int          len;

      bus.pmod_clk = 1'b0; bus.pmod_latch = 1'b0; bus.pmod_data = 1'b0;
      model_reset();

      // reset with pins toggling
      for (int i = 0; i < 3; i++) begin
         bus.pmod_clk = 1'($urandom); bus.pmod_latch = 1'($urandom); bus.pmod_data = 1'($urandom);
         cyc(1);
      end
      check_outputs("reset");
      check("reset.frame_valid", 32'(bus.frame_valid), 0);
      check("reset.frame_err",   32'(bus.frame_err),   0);
      bus.pmod_clk = 1'b0; bus.pmod_latch = 1'b0; bus.pmod_data = 1'b0;
      cyc(1);
      rst = 1'b0;
      cyc(3);

      good_frame("good", 12'h108, 12'hFFF);
      send_bits(32'h0, 23);
      do_latch("short", 1'b0);
      send_bits(32'h2AAAAAA, 26);
      do_latch("long", 1'b0);
      send_bits(32'h155555, 23);
      do_latch("collision", 1'b1);
      good_frame("after_coll", 12'h0F0, 12'h801);
      do_latch("empty", 1'b0);
      good_frame("after_empty", 12'hFFF, 12'h00C);

      prev_err = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (!prev_err && $urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 4))
               0: len = 0;
               1: len = 1;
               2: len = 23;
               3: len = 25;
               default: len = 26;
            endcase
            send_bits($urandom, len);
            do_latch("rand_err", 1'b0);
            prev_err = 1'b1;
         end else begin
            a = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            good_frame("rand_good", a, b);
            prev_err = 1'b0;
         end
      end

      // timeout after the last good frame
      good_frame("to_frame", 12'h3C5, 12'h0A0);
      cyc(900);
      check_outputs("to_before");
      cyc(110);
      m_link = 1'b0; m_p1 = '0; m_p2 = '0; m_p1p = 1'b0; m_p2p = 1'b0;
      check_outputs("to_after");
      good_frame("to_recover", 12'h001, 12'h800);

      // reset in the middle of a frame
      send_bits(32'h3FF, 10);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      model_reset();
      check_outputs("midrst");
      good_frame("midrst_good", 12'h108, 12'h040);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
